// File: rtl/sprite_compositor_if.sv
// Avalon-MM register bus for the sprite compositor: CPU side is master, compositor is slave.
interface sprite_compositor_if;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [8:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport slave  (input  chipselect, write, read, address, writedata, output readdata);
  modport master (output chipselect, write, read, address, writedata, input  readdata);
endinterface

// File: rtl/sprite_compositor.sv
// Three-stage sprite compositor: per-channel hit test / ROM addressing, priority select, colour out.
// Optional sticky collision status register is built when SPRITE_COLLISION_EN is defined.
module sprite_compositor #(
  parameter int unsigned NUM_SPRITES     = 6,
  parameter int unsigned SPRITE_W        = 32,
  parameter int unsigned SPRITE_H        = 32,
  parameter logic [15:0] TRANSPARENT_KEY = 16'hF81F,
  localparam int unsigned AW             = $clog2(SPRITE_W * SPRITE_H)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  sprite_compositor_if.slave        avs,
  input  logic [10:0]               hcount,
  input  logic [9:0]                vcount,
  input  logic                      blank_n_in,
  output logic [NUM_SPRITES*AW-1:0] rom_addr,
  input  logic [NUM_SPRITES*16-1:0] rom_data,
  output logic [7:0]                VGA_R,
  output logic [7:0]                VGA_G,
  output logic [7:0]                VGA_B,
  output logic                      blank_n_out
);

  localparam logic [8:0] A_BG     = 9'h100;
  localparam logic [8:0] A_STATUS = 9'h101;
  localparam logic [8:0] A_FRAME  = 9'h102;

  logic [9:0]  r_x_sh [NUM_SPRITES];
  logic [9:0]  r_y_sh [NUM_SPRITES];
  logic [9:0]  r_x    [NUM_SPRITES];
  logic [9:0]  r_y    [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] r_en_sh, r_en;
  logic [23:0] r_bg_sh, r_bg;
  logic [15:0] r_frame;

  logic [NUM_SPRITES-1:0] w_hit, w_opaque, r_hit;
  logic [AW-1:0]          w_addr [NUM_SPRITES];
  logic        r_blank1, r_blank2, r_valid2;
  logic [15:0] r_data2;
  logic        w_sel_valid;
  logic [15:0] w_sel_data;
  logic [31:0] w_rdata, w_status;
  logic [9:0]  w_px;
  logic        w_wr, w_rd, w_commit;
  logic        w_unused;

  assign w_px     = hcount[10:1];
  assign w_wr     = avs.chipselect && avs.write;
  assign w_rd     = avs.chipselect && avs.read;
  assign w_commit = (vcount == 10'd480) && (hcount == 11'd0);
  assign w_unused = &{1'b0, hcount[0], avs.writedata[31:24]};

  // Shadow registers take bus writes; active copies load at vblank start with the pre-write shadow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_x_sh[i] <= '0;
        r_y_sh[i] <= '0;
        r_x[i]    <= '0;
        r_y[i]    <= '0;
      end
      r_en_sh <= '0;
      r_en    <= '0;
      r_bg_sh <= 24'hFFFFFF;
      r_bg    <= 24'hFFFFFF;
      r_frame <= '0;
    end else begin
      if (w_commit) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          r_x[i] <= r_x_sh[i];
          r_y[i] <= r_y_sh[i];
        end
        r_en    <= r_en_sh;
        r_bg    <= r_bg_sh;
        r_frame <= r_frame + 16'd1;
      end
      if (w_wr) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          if (avs.address == 9'(4*i))     r_x_sh[i]  <= avs.writedata[9:0];
          if (avs.address == 9'(4*i + 1)) r_y_sh[i]  <= avs.writedata[9:0];
          if (avs.address == 9'(4*i + 2)) r_en_sh[i] <= avs.writedata[0];
        end
        if (avs.address == A_BG) r_bg_sh <= avs.writedata[23:0];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (avs.address == 9'(4*i))     w_rdata = 32'(r_x_sh[i]);
      if (avs.address == 9'(4*i + 1)) w_rdata = 32'(r_y_sh[i]);
      if (avs.address == 9'(4*i + 2)) w_rdata = 32'(r_en_sh[i]);
    end
    if (avs.address == A_BG)     w_rdata = 32'(r_bg_sh);
    if (avs.address == A_STATUS) w_rdata = w_status;
    if (avs.address == A_FRAME)  w_rdata = 32'(r_frame);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  avs.readdata <= '0;
    else if (w_rd) avs.readdata <= w_rdata;
  end

  // Hit test in 11 bits so sprites clip at the right/bottom edge instead of wrapping
  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_ch
    logic [10:0] w_px11, w_py11, w_x0, w_y0, w_dx, w_dy;
    assign w_px11 = {1'b0, w_px};
    assign w_py11 = {1'b0, vcount};
    assign w_x0   = {1'b0, r_x[g]};
    assign w_y0   = {1'b0, r_y[g]};
    assign w_dx   = w_px11 - w_x0;
    assign w_dy   = w_py11 - w_y0;
    assign w_hit[g] = r_en[g] && (w_px11 >= w_x0) && (w_px11 < w_x0 + 11'(SPRITE_W))
                              && (w_py11 >= w_y0) && (w_py11 < w_y0 + 11'(SPRITE_H));
    assign w_addr[g]   = w_hit[g] ? AW'(32'(w_dy) * SPRITE_W + 32'(w_dx)) : '0;
    assign w_opaque[g] = r_hit[g] && (rom_data[16*g +: 16] != TRANSPARENT_KEY);
  end

  // Lowest-index opaque channel wins
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (w_opaque[i]) begin
        w_sel_valid = 1'b1;
        w_sel_data  = rom_data[16*i +: 16];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit       <= '0;
      rom_addr    <= '0;
      r_blank1    <= 1'b0;
      r_valid2    <= 1'b0;
      r_data2     <= '0;
      r_blank2    <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      blank_n_out <= 1'b0;
    end else begin
      r_hit    <= w_hit;
      for (int i = 0; i < NUM_SPRITES; i++) rom_addr[i*AW +: AW] <= w_addr[i];
      r_blank1 <= blank_n_in;
      r_valid2 <= w_sel_valid;
      r_data2  <= w_sel_data;
      r_blank2 <= r_blank1;
      blank_n_out <= r_blank2;
      if (!r_blank2) begin
        VGA_R <= '0;
        VGA_G <= '0;
        VGA_B <= '0;
      end else if (r_valid2) begin
        VGA_R <= {r_data2[15:11], r_data2[15:13]};
        VGA_G <= {r_data2[10:5],  r_data2[10:9]};
        VGA_B <= {r_data2[4:0],   r_data2[4:2]};
      end else begin
        VGA_R <= r_bg[23:16];
        VGA_G <= r_bg[15:8];
        VGA_B <= r_bg[7:0];
      end
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic [NUM_SPRITES-1:0] r_status, w_coll;

  always_comb begin
    w_coll = '0;
    for (int i = 1; i < NUM_SPRITES; i++) w_coll[i] = w_opaque[0] && w_opaque[i];
  end

  // A new collision in the same cycle as the clearing read survives
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             r_status <= '0;
    else if (w_rd && avs.address == A_STATUS) r_status <= w_coll;
    else                                      r_status <= r_status | w_coll;
  end

  assign w_status = 32'(r_status);
`else
  assign w_status = '0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: register map, commit timing, priority, clipping, reset.
module tb_sprite_compositor;
  localparam int unsigned N  = 6;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [10:0]   hcount;
  logic [9:0]    vcount;
  logic          blank_n_in;
  logic [N*AW-1:0] rom_addr;
  logic [N*16-1:0] rom_data = '0;
  logic [7:0]    VGA_R, VGA_G, VGA_B;
  logic          blank_n_out;
  logic [15:0]   rom_val [N];
  int            total = 0;
  int            bad   = 0;
  int            frames = 0;
  logic [31:0]   rdv;
  logic [31:0]   bg;

  sprite_compositor_if bus ();

  sprite_compositor dut (
    .clk(clk), .reset_n(reset_n), .avs(bus),
    .hcount(hcount), .vcount(vcount), .blank_n_in(blank_n_in),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .blank_n_out(blank_n_out)
  );

  always #5 clk = ~clk;

  // Per-channel ROM: constant texel per channel, one clock of read latency
  always @(posedge clk)
    for (int i = 0; i < N; i++) rom_data[16*i +: 16] <= rom_val[i];

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rgb();
    return {8'h00, VGA_R, VGA_G, VGA_B};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_px(input int px, input int py, input logic bl);
    hcount     = 11'(px * 2);
    vcount     = 10'(py);
    blank_n_in = bl;
  endtask

  task automatic pix(input string tag, input int px, input int py, input logic bl,
                     input logic [31:0] exp);
    drive_px(px, py, bl);
    tick(); tick(); tick();
    chk(tag, rgb(), exp);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    bus.chipselect = 1'b1; bus.write = 1'b1;
    bus.address = 9'(a);   bus.writedata = d;
    tick();
    bus.chipselect = 1'b0; bus.write = 1'b0;
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    bus.chipselect = 1'b1; bus.read = 1'b1;
    bus.address = 9'(a);
    tick();
    bus.chipselect = 1'b0; bus.read = 1'b0;
    d = bus.readdata;
  endtask

  task automatic commit();
    hcount = 11'd0;
    vcount = 10'd480;
    tick();
    vcount = 10'd0;
    frames++;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
    bus.address = '0; bus.writedata = '0;
    hcount = '0; vcount = '0; blank_n_in = 1'b0;
    for (int i = 0; i < N; i++) rom_val[i] = 16'h0000;
    #2;
    chk("rst_rgb", rgb(), 32'h0);
    chk("rst_blank", 32'(blank_n_out), 32'h0);
    chk("rst_readdata", bus.readdata, 32'h0);
    tick(); tick(); tick();
    reset_n = 1'b1;
    tick();

    rd(12'h100, rdv); chk("bg_reset", rdv, 32'h00FFFFFF);
    rd(12'h102, rdv); chk("frame_reset", rdv, 32'h0);
    rd(12'h101, rdv); chk("status_reset", rdv, 32'h0);
    rd(12'h103, rdv); chk("unmapped_rd", rdv, 32'h0);

    // Idle frame: background on active pixels, black while blanked
    pix("idle_active", 10, 10, 1'b1, 32'h00FFFFFF);
    chk("idle_blank_hi", 32'(blank_n_out), 32'h1);
    pix("idle_blanked", 10, 10, 1'b0, 32'h0);
    chk("idle_blank_lo", 32'(blank_n_out), 32'h0);

    wr(12'h100, 32'h00123456);
    pix("bg_pre_commit", 10, 10, 1'b1, 32'h00FFFFFF);
    commit();
    bg = 32'h00123456;
    pix("bg_post_commit", 10, 10, 1'b1, bg);

    // Channel 0 green at (100,100)
    wr(0, 100); wr(1, 100); wr(2, 1);
    rom_val[0] = 16'h07E0;
    pix("ch0_pre_commit", 100, 100, 1'b1, bg);
    commit();
    rd(12'h102, rdv); chk("frame_cnt2", rdv, 32'(frames));
    drive_px(105, 103, 1'b1);
    tick();
    chk("rom_addr_hit", 32'(rom_addr[AW-1:0]), 32'd101);
    tick(); tick();
    chk("ch0_105_103", rgb(), 32'h0000FF00);
    pix("ch0_tl", 100, 100, 1'b1, 32'h0000FF00);
    pix("ch0_br", 131, 131, 1'b1, 32'h0000FF00);
    pix("ch0_left", 99, 100, 1'b1, bg);
    pix("ch0_right", 132, 100, 1'b1, bg);
    pix("ch0_below", 100, 132, 1'b1, bg);
    pix("ch0_above", 100, 99, 1'b1, bg);
    drive_px(100, 100, 1'b1);
    tick(); tick();
    chk("latency_2clk", rgb(), bg);
    tick();
    chk("latency_3clk", rgb(), 32'h0000FF00);
    drive_px(10, 10, 1'b1);
    tick();
    chk("rom_addr_miss", 32'(|rom_addr), 32'h0);

    // Overlap of channels 0 and 1
    wr(4, 100); wr(5, 100); wr(6, 1);
    rom_val[0] = 16'hF800; rom_val[1] = 16'h001F;
    commit();
    pix("prio_red", 110, 110, 1'b1, 32'h00FF0000);
    rom_val[0] = 16'hF81F;
    pix("ch0_transp", 110, 110, 1'b1, 32'h000000FF);
    rom_val[0] = 16'h8410;
    pix("expand_8410", 110, 110, 1'b1, 32'h00848284);
    rom_val[0] = 16'hF81F; rom_val[1] = 16'hF81F;
    pix("both_transp", 110, 110, 1'b1, bg);

    // Mid-frame write goes to shadow only
    wr(6, 0);
    rom_val[0] = 16'h07E0;
    commit();
    drive_px(0, 50, 1'b1);
    wr(0, 200);
    pix("midframe_old", 100, 100, 1'b1, 32'h0000FF00);
    pix("midframe_new", 200, 100, 1'b1, bg);
    rd(0, rdv); chk("shadow_read", rdv, 32'd200);
    commit();
    pix("nextframe_new", 200, 100, 1'b1, 32'h0000FF00);
    pix("nextframe_old", 100, 100, 1'b1, bg);

    // Write landing on the commit cycle waits one more frame
    hcount = 11'd0; vcount = 10'd480;
    wr(0, 300);
    frames++;
    vcount = 10'd0;
    pix("cwrite_old", 200, 100, 1'b1, 32'h0000FF00);
    pix("cwrite_new_pend", 300, 100, 1'b1, bg);
    commit();
    pix("cwrite_applied", 300, 100, 1'b1, 32'h0000FF00);
    rd(12'h102, rdv); chk("frame_cnt7", rdv, 32'(frames));

    // Right-edge clipping on channel 2
    wr(2, 0);
    wr(8, 630); wr(9, 0); wr(10, 1);
    rom_val[2] = 16'h07E0;
    commit();
    pix("clip_630", 630, 10, 1'b1, 32'h0000FF00);
    pix("clip_639", 639, 10, 1'b1, 32'h0000FF00);
    pix("clip_629", 629, 10, 1'b1, bg);
    pix("clip_px0", 0, 10, 1'b1, bg);
    wr(8, 1000);
    commit();
    pix("nowrap_px0", 0, 10, 1'b1, bg);
    pix("nowrap_px5", 5, 10, 1'b1, bg);
    pix("x1000_px1005", 1005, 10, 1'b1, 32'h0000FF00);

    // Asynchronous reset mid-line
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_rgb", rgb(), 32'h0);
    chk("async_rst_blank", 32'(blank_n_out), 32'h0);
    tick(); tick();
    reset_n = 1'b1;
    frames = 0;
    tick();
    rd(12'h100, rdv); chk("bg_after_rst", rdv, 32'h00FFFFFF);
    rd(12'h102, rdv); chk("frame_after_rst", rdv, 32'(frames));
    rd(8, rdv);       chk("x2_after_rst", rdv, 32'h0);
    pix("pix_after_rst", 1005, 10, 1'b1, 32'h00FFFFFF);

    // Channels 0 and 3 overlapping, both opaque
    wr(0, 100); wr(1, 100); wr(2, 1);
    wr(12, 100); wr(13, 100); wr(14, 1);
    rom_val[0] = 16'hF800; rom_val[3] = 16'h001F;
    commit();
    pix("coll_prio", 105, 105, 1'b1, 32'h00FF0000);
    drive_px(0, 0, 1'b1);
    tick(); tick();
`ifdef SPRITE_COLLISION_EN
    rd(12'h101, rdv); chk("coll_status", rdv, 32'h8);
    rd(12'h101, rdv); chk("coll_cleared", rdv, 32'h0);
`else
    rd(12'h101, rdv); chk("status_off", rdv, 32'h0);
    rd(12'h101, rdv); chk("status_off2", rdv, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
